if_prefetch_unit: RTL and testbench

IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

---
 rtl/if_pkg.sv | 18 +
 rtl/if_fifo.sv | 81 ++++++++
 rtl/if_prefetch_unit.sv | 175 +++++++++++++++++
 tb/tb_if_prefetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg
//   Shared definitions for the instruction prefetch unit.
//   - if_state_e : fetch FSM state encoding.
//   - inst_bytes : byte width of one instruction, used as the fetch PC step.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no request
    REQ   = 2'd1,  // ic_req high, waiting for acceptance
    WAIT  = 2'd2,  // request accepted, waiting for ic_done
    DRAIN = 2'd3   // waiting for a response that will be thrown away
  } if_state_e;

  function automatic int unsigned inst_bytes(input int unsigned inst_w);
    return inst_w / 8;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// if_fifo
//   Small synchronous FIFO with flush. The head entry is presented
//   combinationally from the storage array. While the FIFO is empty the head
//   reads as zero, so downstream sees clean outputs after reset or flush.
// Parameters
//   WIDTH : entry width in bits
//   DEPTH : number of entries, power of 2, at least 2
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   i_flush      : discard all entries (wins over push and pop)
//   i_push       : write i_push_data at the tail
//   i_pop        : drop the head entry (ignored while empty)
//   o_head       : head entry, zero while empty
//   o_count      : occupancy
//   o_full       : occupancy equals DEPTH
//   o_empty      : occupancy is zero
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

  // A push into a full FIFO is only accepted when a pop frees a slot the
  // same cycle; flush discards both.
  assign w_pop  = i_pop && !o_empty && !i_flush;
  assign w_push = i_push && (!o_full || w_pop) && !i_flush;

  // Storage has no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit
//   Instruction prefetcher: issues sequential single-instruction reads to the
//   ICache, queues the returned instructions with their addresses, and hands
//   them to decode in order. A redirect flushes the queue and restarts
//   fetching at the new target; a response already in flight is drained and
//   discarded.
// Optional feature
//   IF_PERF_CNT_EN : adds perf_stall_cnt, a saturating 32-bit count of cycles
//                    with no valid instruction and no redirect.
// Parameters
//   ADDR_W, INST_W (multiple of 8), QDEPTH (power of 2, >= 2), RESET_PC
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   redirect_valid, redirect_pc : branch/exception redirect
//   ic_req, ic_addr             : ICache read request and address
//   ic_busy                     : ICache cannot accept a request this cycle
//   ic_done, ic_rdata           : response pulse and returned instruction
//   inst_valid, inst, inst_pc   : queue head to decode
//   inst_ready                  : decode consumes the head
//   stall_req                   : no instruction available
//   perf_stall_cnt              : stall cycle counter (IF_PERF_CNT_EN only)
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ic_req,
  output logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_busy,
  input  logic              ic_done,
  input  logic [INST_W-1:0] ic_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              stall_req
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int                ENT_W   = INST_W + ADDR_W;
  localparam int                CNT_W   = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(inst_bytes(INST_W));

  generate
    if ((INST_W % 8) != 0) begin : g_bad_inst_w
      $error("if_prefetch_unit: INST_W must be a multiple of 8");
    end
    if ((QDEPTH < 2) || ((QDEPTH & (QDEPTH - 1)) != 0)) begin : g_bad_qdepth
      $error("if_prefetch_unit: QDEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  if_state_e         r_state;
  if_state_e         w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_next;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [ENT_W-1:0]  w_head;
  logic              w_room;

  // A new request is only started when the queue can take its response.
  // Only our own response ever pushes, so the slot stays reserved until the
  // data returns.
  assign w_room = (w_count < CNT_W'(QDEPTH));

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_push          = 1'b0;
    w_flush         = 1'b0;
    if (redirect_valid) begin
      // Redirect beats every other event this cycle, including a response
      // arriving right now (that data is dropped).
      w_flush         = 1'b1;
      w_fetch_pc_next = redirect_pc;
      case (r_state)
        WAIT, DRAIN: w_state_next = ic_done ? IDLE : DRAIN;
        default:     w_state_next = IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (w_room) begin
            w_state_next = REQ;
          end
        end
        REQ: begin
          if (!ic_busy) begin
            w_state_next = WAIT;
          end
        end
        WAIT: begin
          if (ic_done) begin
            // Full is impossible here thanks to the reserved slot; the gate
            // only keeps a corrupted count from overwriting the head.
            w_push          = !w_full;
            w_fetch_pc_next = r_fetch_pc + PC_STEP;
            w_state_next    = IDLE;
          end
        end
        DRAIN: begin
          if (ic_done) begin
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  assign w_pop = inst_valid && inst_ready && !redirect_valid;

  if_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_push_data ({ic_rdata, r_fetch_pc}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign ic_req     = (r_state == REQ);
  assign ic_addr    = r_fetch_pc;
  assign inst_valid = !w_empty;
  assign inst       = w_head[ENT_W-1 -: INST_W];
  assign inst_pc    = w_head[ADDR_W-1:0];
  assign stall_req  = !inst_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall_cnt <= '0;
    end else if (!inst_valid && !redirect_valid && (r_perf_stall_cnt != '1)) begin
      r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Testbench for if_prefetch_unit (default parameters). The bench plays the
// ICache (one outstanding read, random latency) and keeps a transaction-level
// reference: a queue of {instruction, pc} plus the fetch pointer and a note
// of whether a request is being offered, in flight, or will be discarded.
module tb_if_prefetch_unit;

  localparam int QD   = 4;
  localparam int STEP = 4;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_busy;
  logic        ic_done;
  logic [31:0] ic_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        stall_req;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] m_perf;
`endif

  if_prefetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_busy        (ic_busy),
    .ic_done        (ic_done),
    .ic_rdata       (ic_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .stall_req      (stall_req)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  // Reference model
  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_offer;     // request being offered to the ICache
  bit          m_flight;    // accepted, response will be queued
  bit          m_discard;   // accepted, response will be dropped
  bit          m_was_rst;

  // ICache model
  bit          c_out;
  int          c_lat;
  int          lat_min;
  int          lat_max;
  int          acc_cnt;
  logic [31:0] acc_addr[$];

  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference update at the clock edge, from the inputs driven this cycle.
  task automatic model_step();
    bit          idle;
    int          sz;
    logic [31:0] rdata;
    idle  = !m_offer && !m_flight && !m_discard;
    sz    = m_q.size();
    rdata = ic_rdata;

    if (ic_done) c_out = 0;
    if (!rst && !redirect_valid && m_offer && !ic_busy) begin
      c_out = 1;
      c_lat = $urandom_range(lat_max, lat_min);
      acc_cnt++;
      acc_addr.push_back(m_pc);
    end

`ifdef IF_PERF_CNT_EN
    if (rst) m_perf = 0;
    else if (sz == 0 && !redirect_valid && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
`endif

    m_was_rst = rst;
    if (rst) begin
      m_q.delete();
      m_pc      = 32'h0;
      m_offer   = 0;
      m_flight  = 0;
      m_discard = 0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_pc      = redirect_pc;
      m_discard = (m_flight || m_discard) && !ic_done;
      m_flight  = 0;
      m_offer   = 0;
    end else begin
      if (sz > 0 && inst_ready) void'(m_q.pop_front());
      if (m_offer) begin
        if (!ic_busy) begin
          m_offer  = 0;
          m_flight = 1;
        end
      end else if (m_flight) begin
        if (ic_done) begin
          m_q.push_back('{data: rdata, pc: m_pc});
          m_pc     = m_pc + STEP;
          m_flight = 0;
        end
      end else if (m_discard) begin
        if (ic_done) m_discard = 0;
      end else if (idle && sz < QD) begin
        m_offer = 1;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("ic_req", ic_req, m_offer);
    if (m_offer) check_eq("ic_addr", ic_addr, m_pc);
    check_eq("inst_valid", inst_valid, m_q.size() > 0);
    check_eq("stall_req", stall_req, m_q.size() == 0);
    if (m_q.size() > 0) begin
      check_eq("inst", inst, m_q[0].data);
      check_eq("inst_pc", inst_pc, m_q[0].pc);
    end else if (m_was_rst) begin
      check_eq("rst_inst", inst, 0);
      check_eq("rst_inst_pc", inst_pc, 0);
    end
`ifdef IF_PERF_CNT_EN
    check_eq("perf_cnt", perf_stall_cnt, m_perf);
`endif
  endtask

  // One clock cycle: drive at the falling edge, model at the rising edge,
  // compare at the next falling edge.
  task automatic cyc(input bit r, input bit rv, input logic [31:0] rpc,
                     input bit busy, input bit rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    ic_busy        = c_out ? 1'b1 : busy;
    ic_done        = 1'b0;
    ic_rdata       = $urandom;
    if (c_out) begin
      if (c_lat == 0) ic_done = 1'b1;
      else c_lat--;
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
  endtask

  initial begin
    bit          r;
    bit          rv;
    logic [31:0] rpc;
    n_tests = 0;
    n_fail  = 0;
    c_out   = 0;
    c_lat   = 0;
    lat_min = 0;
    lat_max = 0;
    acc_cnt = 0;
    m_offer = 0; m_flight = 0; m_discard = 0; m_pc = 0; m_was_rst = 0;
`ifdef IF_PERF_CNT_EN
    m_perf = 0;
`endif
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    ic_busy = 1'b0; ic_done = 1'b0; ic_rdata = '0; inst_ready = 1'b0;
    @(negedge clk);

    // Sequential fetch with a 1-cycle ICache
    do_reset();
    acc_addr.delete();
    cyc(0, 0, 0, 0, 1);
    check_eq("first_req", ic_req, 1);
    check_eq("first_addr", ic_addr, 32'h0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 1);
    check_eq("seq_n", acc_addr.size() >= 3, 1);
    if (acc_addr.size() >= 3) begin
      check_eq("seq0", acc_addr[0], 32'h0);
      check_eq("seq1", acc_addr[1], 32'h4);
      check_eq("seq2", acc_addr[2], 32'h8);
    end

    // Queue fills, fetch stops, one pop allows exactly one more fetch
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, 0);
    check_eq("fill_acc", acc_cnt, 4);
    check_eq("fill_req", ic_req, 0);
    check_eq("fill_valid", inst_valid, 1);
    cyc(0, 0, 0, 0, 1);
    acc_cnt = 0;
    acc_addr.delete();
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0);
    check_eq("refill_acc", acc_cnt, 1);
    if (acc_addr.size() > 0) check_eq("refill_addr", acc_addr[0], 32'h10);

    // ICache busy holds the request
    do_reset();
    acc_cnt = 0;
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1);
    check_eq("busy_acc", acc_cnt, 0);
    check_eq("busy_req", ic_req, 1);
    cyc(0, 0, 0, 0, 1);
    check_eq("busy_acc1", acc_cnt, 1);

    // Redirect in WAIT, response the following cycle is dropped
    do_reset();
    lat_min = 1; lat_max = 1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 32'h100, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check_eq("drop_empty", inst_valid, 0);
    acc_addr.delete();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    if (acc_addr.size() > 0) check_eq("redir_addr", acc_addr[0], 32'h100);
    else check_eq("redir_acc", acc_addr.size(), 1);

    // Redirect coincident with ic_done and a pop
    do_reset();
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
    check_eq("pre_valid", inst_valid, 1);
    cyc(0, 1, 32'h200, 0, 1);
    check_eq("coinc_empty", inst_valid, 0);
    acc_addr.delete();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    if (acc_addr.size() > 0) check_eq("coinc_addr", acc_addr[0], 32'h200);
    else check_eq("coinc_acc", acc_addr.size(), 1);

`ifdef IF_PERF_CNT_EN
    // Stall counter counts every starved cycle
    do_reset();
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1);
    check_eq("perf10", perf_stall_cnt, 32'd10);
`endif

    // Random traffic
    lat_min = 0; lat_max = 3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 99) < 4);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cyc(r, rv, rpc, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the stimulus is fully bounded, so this only fires on a hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
